// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage feeding the single-cycle control unit. Owns the PC, issues
// in-order word fetches over a req/gnt/rvalid handshake (at most one request
// in flight), buffers returned words in a small FIFO and presents the head
// instruction plus its opCode/func fields. A taken branch on the consumed
// head (pcSrc) redirects the PC, flushes the FIFO and squashes any stale
// in-flight response.
//
// Parameters:
//   RESET_PC    first fetch address after reset (word aligned)
//   IBUF_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imemReq/imemAddr      fetch request and byte address (== fetch PC)
//   imemGnt               request accepted when imemReq & imemGnt
//   imemRvalid/imemRdata  in-order response and instruction word
//   instrValid/instrReady head valid / downstream consume handshake
//   instr/opCode/func     head instruction and its [31:26] / [5:0] fields
//   instrPc               address of the head instruction
//   pcSrc/branchImm       taken branch and immediate for the consumed head
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [5:0]  func,
    output logic [31:0] instrPc,
    input  logic        pcSrc,
    input  logic [15:0] branchImm
);

    localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);

    logic [31:0]      r_fetchPc;
    logic             r_running;
    logic             r_outstanding;
    logic             r_squash;
    logic [31:0]      r_reqPc;
    logic [31:0]      r_pcMem  [IBUF_DEPTH];
    logic [31:0]      r_insMem [IBUF_DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic             w_consume;
    logic             w_redirect;
    logic             w_accept;
    logic             w_respValid;
    logic             w_push;
    logic [31:0]      w_target;

    assign instrValid  = (r_count != '0);
    assign instr       = r_insMem[r_rdPtr];
    assign instrPc     = r_pcMem[r_rdPtr];
    assign opCode      = instr[31:26];
    assign func        = instr[5:0];

    assign w_consume   = instrValid & instrReady;
    assign w_redirect  = w_consume & pcSrc;

    // Single outstanding request; blocked in the redirect cycle so the old
    // sequential address is never issued after a taken branch.
    assign imemReq     = r_running & ~r_outstanding & ~w_redirect
                       & (r_count < CNT_W'(IBUF_DEPTH));
    assign imemAddr    = r_fetchPc;
    assign w_accept    = imemReq & imemGnt;

    // Responses with nothing in flight (e.g. from before a reset) are ignored.
    assign w_respValid = imemRvalid & r_outstanding;
    assign w_push      = w_respValid & ~r_squash & ~w_redirect;

    assign w_target    = instrPc + 32'd4 + {{14{branchImm[15]}}, branchImm, 2'b00};

    // PC and handshake control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running     <= 1'b0;
            r_fetchPc     <= RESET_PC;
            r_outstanding <= 1'b0;
            r_squash      <= 1'b0;
            r_reqPc       <= '0;
        end else begin
            r_running <= 1'b1;

            if (w_redirect) begin
                r_fetchPc <= w_target;
            end else if (w_accept) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end

            // accept needs !outstanding and a response needs outstanding,
            // so the two never coincide.
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_reqPc       <= r_fetchPc;
            end else if (w_respValid) begin
                r_outstanding <= 1'b0;
            end

            // A redirect whose response is still in flight marks that
            // response stale; outstanding stays set until it arrives.
            if (w_respValid) begin
                r_squash <= 1'b0;
            end else if (w_redirect && r_outstanding) begin
                r_squash <= 1'b1;
            end
        end
    end

    // Instruction buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < IBUF_DEPTH; i++) begin
                r_pcMem[PTR_W'(i)]  <= '0;
                r_insMem[PTR_W'(i)] <= '0;
            end
        end else if (w_redirect) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pcMem[r_wrPtr]  <= r_reqPc;
                r_insMem[r_wrPtr] <= imemRdata;
                r_wrPtr           <= r_wrPtr + PTR_W'(1);
            end
            if (w_consume) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_consume})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A behavioural memory answers accepted requests
// after a chosen latency with a word derived from the address. The reference
// keeps the expected buffered {pc, instr} entries in a queue and tracks the
// architectural PC stream (next consumed PC = previous + 4, or the branch
// target when the previous consume was taken).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [5:0]  opCode;
    logic [5:0]  func;
    logic [31:0] instrPc;
    logic        pcSrc;
    logic [15:0] branchImm;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instr      (instr),
        .opCode     (opCode),
        .func       (func),
        .instrPc    (instrPc),
        .pcSrc      (pcSrc),
        .branchImm  (branchImm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          n_vec = 0;
    int          n_bad = 0;

    // reference state
    ent_t        q[$];
    logic [31:0] m_fpc   = RESET_PC;
    logic [31:0] m_ra    = '0;
    logic [31:0] exp_pc  = RESET_PC;
    bit          m_run   = 0;
    bit          m_out   = 0;
    bit          m_sq    = 0;
    int          n_stray = 0;

    // memory model
    bit          mb = 0;
    logic [31:0] ma = '0;
    int unsigned mw = 0;
    logic [31:0] acc_log[$];

    // stimulus policy
    int unsigned gnt_pct = 100, rdy_pct = 100, br_pct = 0;
    int unsigned lat_min = 1, lat_max = 1;
    bit          hold_en = 0;
    logic [31:0] hold_pc = '0;
    bit          br_arm = 0, br_any = 0;
    logic [31:0] br_pc  = '0;
    logic [15:0] br_imm = '0;

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out  = 0;
        m_sq   = 0;
        m_run  = 0;
        m_fpc  = RESET_PC;
        exp_pc = RESET_PC;
    endtask

    task automatic cycle();
        logic        resp, cons, redir, req_e, acc_m, acc_d;
        logic [31:0] tgt, off, hd_ins, acc_a;
        ent_t        e;
        @(negedge clk);
        resp       = mb && (mw == 1);
        imemRvalid = resp;
        imemRdata  = resp ? dat(ma) : $urandom();
        imemGnt    = ($urandom_range(99) < gnt_pct);
        if (hold_en && q.size() != 0 && q[0].pc == hold_pc) instrReady = 1'b0;
        else instrReady = ($urandom_range(99) < rdy_pct);
        if (br_arm && (br_any || (q.size() != 0 && q[0].pc == br_pc))) begin
            pcSrc     = 1'b1;
            branchImm = br_imm;
        end else begin
            pcSrc     = ($urandom_range(99) < br_pct);
            branchImm = 16'($urandom());
        end
        #1;
        chk("instrValid", instrValid, q.size() != 0);
        if (q.size() != 0) begin
            hd_ins = q[0].ins;
            chk("instrPc", instrPc, q[0].pc);
            chk("instr", instr, hd_ins);
            chk("opCode", opCode, hd_ins[31:26]);
            chk("func", func, hd_ins[5:0]);
        end
        cons  = (q.size() != 0) && instrReady;
        redir = cons && pcSrc;
        req_e = m_run && !m_out && !redir && (q.size() < DEPTH);
        chk("imemReq", imemReq, req_e);
        chk("imemAddr", imemAddr, m_fpc);
        acc_m = req_e && imemGnt;
        acc_d = (imemReq === 1'b1) && imemGnt;
        acc_a = imemAddr;
        off   = {{16{branchImm[15]}}, branchImm};
        tgt   = exp_pc + 32'd4 + off * 32'd4;
        if (cons) begin
            chk("archPc", instrPc, exp_pc);
            chk("archInstr", instr, dat(exp_pc));
        end
        @(posedge clk);
        // memory
        if (resp) mb = 0;
        else if (mb && mw > 1) mw--;
        if (acc_d) begin
            acc_log.push_back(acc_a);
            if (!mb) begin
                mb = 1;
                ma = acc_a;
                mw = $urandom_range(lat_max, lat_min);
            end
        end
        // reference
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            if (resp && !m_out) n_stray++;
            if (redir) begin
                if (resp && m_out) begin
                    m_out = 0;
                    m_sq  = 0;
                end else if (m_out) begin
                    m_sq = 1;
                end
                q.delete();
                m_fpc  = tgt;
                exp_pc = tgt;
                br_arm = 0;
            end else begin
                if (cons) begin
                    void'(q.pop_front());
                    exp_pc = exp_pc + 32'd4;
                end
                if (resp && m_out) begin
                    m_out = 0;
                    if (m_sq) m_sq = 0;
                    else begin
                        e.pc  = m_ra;
                        e.ins = dat(m_ra);
                        q.push_back(e);
                    end
                end
            end
            if (acc_m) begin
                m_out = 1;
                m_ra  = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
            m_run = 1;
        end
    endtask

    task automatic do_reset(input bit keep_mem);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstValid", instrValid, 1'b0);
        chk("rstReq", imemReq, 1'b0);
        chk("rstAddr", imemAddr, RESET_PC);
        chk("rstInstr", instr, 32'd0);
        chk("rstPc", instrPc, 32'd0);
        chk("rstOp", opCode, 6'd0);
        chk("rstFunc", func, 6'd0);
        model_reset();
        if (!keep_mem) mb = 0;
        cycle();
        cycle();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0, waited, k;
        logic [31:0] tgt_exp;
        rst_n = 1'b1; imemGnt = 0; imemRvalid = 0; imemRdata = '0;
        instrReady = 0; pcSrc = 0; branchImm = '0;

        // fill with head stalled, then drain in order
        do_reset(0);
        acc_log.delete();
        gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 0;
        repeat (10) cycle();
        chk("fillAcc", acc_log.size(), DEPTH);
        rdy_pct = 100;
        repeat (12) cycle();
        chk("firstAddr0", acc_log[0], 32'h0);
        chk("firstAddr1", acc_log[1], 32'h4);
        chk("firstAddr2", acc_log[2], 32'h8);

        // taken branch from 0x10 with nothing in flight
        do_reset(0);
        hold_en = 1; hold_pc = 32'h10;
        for (int i = 0; i < 40 && !(q.size() == 2 && q[0].pc == 32'h10 && !m_out); i++) cycle();
        chk("holdReached", q.size() == 2 && q[0].pc == 32'h10 && !m_out, 1'b1);
        hold_en = 0; br_arm = 1; br_any = 0; br_pc = 32'h10; br_imm = 16'hFFFC;
        cycle();
        #2;
        chk("redirAddr", imemAddr, 32'h4);
        chk("redirFlush", instrValid, 1'b0);
        n0 = acc_log.size();
        cycle();
        chk("redirNextAcc", acc_log.size(), n0 + 1);
        if (acc_log.size() > n0) chk("redirNextAddr", acc_log[n0], 32'h4);

        // wrap: 0x4 -> 0xFFFF_FFFC -> 0x0
        br_arm = 1; br_pc = 32'h4; br_imm = 16'hFFFD;
        for (int i = 0; i < 40 && br_arm; i++) cycle();
        chk("brUsedHi", br_arm, 1'b0);
        #2;
        chk("wrapAddrHi", imemAddr, 32'hFFFF_FFFC);
        br_arm = 1; br_pc = 32'hFFFF_FFFC; br_imm = 16'h0000;
        for (int i = 0; i < 40 && br_arm; i++) cycle();
        chk("brUsedWrap", br_arm, 1'b0);
        #2;
        chk("wrapAddr0", imemAddr, 32'h0);
        repeat (6) cycle();

        // redirect while a slow response is in flight
        do_reset(0);
        rdy_pct = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && !(q.size() >= 1 && mb && mw >= 2); i++) cycle();
        chk("squashSetup", q.size() >= 1 && mb && mw >= 2, 1'b1);
        tgt_exp = exp_pc + 32'd4 + 32'h40;
        br_arm = 1; br_any = 1; br_imm = 16'h0010; rdy_pct = 100;
        cycle();
        k = mw;
        n0 = acc_log.size(); waited = 0;
        while (acc_log.size() == n0 && waited < 20) begin
            cycle();
            waited++;
        end
        chk("squashWait", waited, k + 1);
        if (acc_log.size() > n0) chk("squashTgt", acc_log[n0], tgt_exp);
        repeat (8) cycle();

        // redirect in the same cycle as the response
        do_reset(0);
        br_any = 0; rdy_pct = 0; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 40 && !(q.size() >= 1 && mb && mw == 1); i++) cycle();
        chk("sameSetup", q.size() >= 1 && mb && mw == 1, 1'b1);
        tgt_exp = exp_pc + 32'd4;
        br_arm = 1; br_any = 1; br_imm = 16'h0000; rdy_pct = 100;
        cycle();
        br_any = 0;
        #2;
        chk("sameReq", imemReq, 1'b1);
        chk("sameValid", instrValid, 1'b0);
        n0 = acc_log.size();
        cycle();
        chk("sameAcc", acc_log.size(), n0 + 1);
        if (acc_log.size() > n0) chk("sameTgt", acc_log[n0], tgt_exp);
        repeat (6) cycle();

        // reset mid-wait with one entry buffered; late response ignored
        do_reset(0);
        rdy_pct = 0; lat_min = 4; lat_max = 4;
        for (int i = 0; i < 40 && !(q.size() == 1 && mb && mw >= 3); i++) cycle();
        chk("rstSetup", q.size() == 1 && mb && mw >= 3, 1'b1);
        gnt_pct = 0;
        n0 = n_stray;
        do_reset(1);
        repeat (4) cycle();
        chk("lateResp", n_stray - n0, 1);
        #2;
        chk("lateIgnored", instrValid, 1'b0);
        gnt_pct = 100;
        n0 = acc_log.size();
        for (int i = 0; i < 10 && acc_log.size() == n0; i++) cycle();
        chk("restartAcc", acc_log.size() > n0, 1'b1);
        if (acc_log.size() > n0) chk("restartAddr", acc_log[n0], RESET_PC);

        // random traffic
        do_reset(0);
        gnt_pct = 70; lat_min = 1; lat_max = 4; rdy_pct = 60; br_pct = 15;
        repeat (400) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
